blink_meter: RTL and testbench
==============================

# blink_meter

Receive-side companion to the counter/blinker pair: samples an asynchronous blink waveform such as `blink_wire`, locks onto its rising edges, and reports the measured period and high time in clock cycles. It sits next to the blinker in `tt_um_mrmola` and closes the loop so the bench, or a later on-chip self-check, can confirm the blinker's output rate from the waveform alone.

## Interface
- `WIDTH`, 16: width of the internal cycle counter and the measurement outputs.
- `MIN_PERIOD`, 4: a measured period below this value is rejected as a glitch.

- `clk`  in  1  sole clock; all state is updated on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  measurement enable, synchronous to `clk`.
- `blink_in`  in  1  blink waveform, asynchronous to `clk`.
- `period`  out  WIDTH  last accepted period in cycles; reset value 0.
- `high_time`  out  WIDTH  high time of the last accepted period in cycles; reset value 0.
- `valid`  out  1  one-cycle pulse when `period` and `high_time` update; reset value 0.
- `locked`  out  1  high while at least one valid period has been accepted and no timeout has occurred since; reset value 0.
- `timeout`  out  1  counter saturated with no rising edge; held high until the next accepted rising edge; reset value 0.

## Operation
- Input path: `blink_in` passes through a 2-flop synchronizer (`s1`, `s2`), then an edge register `s3`.
  - `rise` = `s2 & ~s3`
  - `fall` = `~s2 & s3`
- States:
  - IDLE: waits for `rise`. On `rise`, go to MEASURE with `cnt` = 1 and `hcnt` = 1.
  - MEASURE: `cnt` increments every cycle. `hcnt` increments while `s3` is high.
    - On `fall`: `hi_lat` <= `hcnt`.
    - On `rise` with `cnt` ≥ `MIN_PERIOD`: `period` <= `cnt`, `high_time` <= `hi_lat`, pulse `valid`, set `locked`, clear `timeout`. Then `cnt` <= 1 and `hcnt` <= 1.
    - On `rise` with `cnt` < `MIN_PERIOD`: no output update and no `valid`. `cnt` and `hcnt` continue counting, so the glitch edge is ignored.
- Saturation: when `cnt` = 2^WIDTH−1 and no `rise` occurs:
  - set `timeout`, clear `locked`, go to IDLE;
  - `period` and `high_time` hold their values.
- `ena` low:
  - forces IDLE and clears `cnt`, `hcnt` and `locked`;
  - `period`, `high_time` and `timeout` hold;
  - the synchronizer keeps running.
- `rise` and `fall` are mutually exclusive by construction. A `rise` on the same cycle that `cnt` would saturate counts as a `rise`, and no timeout is flagged.
- Arithmetic:
  - all counters are unsigned WIDTH bits;
  - `cnt` never wraps: it saturates;
  - `hcnt` ≤ `cnt` always.
- First period after lock-on: `high_time` is the high time that started at the locking `rise`.

## Timing
- Latency from a `blink_in` rising transition (setup met at edge k) to `rise`: `rise` is high in the cycle after edge k+1.
- `valid` is registered at edge k+2 and is visible for exactly one cycle after it.
- Measured `period` equals the true waveform period in cycles, with ±1 jitter from synchronizer sampling of asynchronous edges. A `clk`-aligned waveform gives an exact result.
- `valid` never asserts on two consecutive cycles, because `MIN_PERIOD` ≥ 2 is required. A `MIN_PERIOD` < 2 is an elaboration error.
- Reset mid-measurement: all outputs go to their reset values immediately and asynchronously. The block returns to IDLE. The synchronizer flops clear to 0.

## Configuration
- `BLINK_METER_GLITCH_EN`:
  - Defined: a 3-sample majority/stability filter sits between `s2` and `s3`. `s3` takes the new level only after `s2` has held it for 3 consecutive cycles. Pulses shorter than 3 cycles are dropped, and `rise`/`fall` latency grows by 2 cycles. Period and high time are unchanged for clean waveforms, since both edges are delayed equally.
  - Undefined: `s3` <= `s2` directly, and no filtering is applied.

## Test plan
- Reset: assert `rst` mid-MEASURE → `period` = 0, `high_time` = 0, `valid` = 0, `locked` = 0, `timeout` = 0 in the same cycle, with no waiting for `clk`.
- Clean waveform, `clk`-aligned, 5 high / 3 low, `ena` = 1 → first `valid` on the 2nd rising edge, with `period` = 8 and `high_time` = 5; `locked` = 1; one `valid` every 8 cycles thereafter.
- Glitch, with `MIN_PERIOD` = 4 on a period of 10 and a 1-cycle spike 2 cycles after a `rise`:
  - macro undefined → no `valid` for the spike; next `valid` reports `period` = 10.
  - macro defined → spike invisible; `high_time` unchanged.
- Timeout with `WIDTH` = 8: stop toggling after lock → `timeout` = 1 and `locked` = 0 exactly 255 cycles after the last `rise`. `period` holds. The next two rising edges clear `timeout` and produce `valid`.
- `ena` dropped for 20 cycles during lock → `locked` = 0 and no `valid` during the gap. After re-enable, the first `valid` appears one full period after the first `rise`.
- Blinker loopback: drive `blink_in` from `blinker(counter)` → `period` equals the blinker's toggle period × 2, and `high_time` equals the blinker's high phase.

Source files
------------

// File: rtl/blink_meter.sv
// blink_meter: locks onto rising edges of an asynchronous blink waveform and reports period/high time in cycles.
// Define BLINK_METER_GLITCH_EN to insert a 3-sample stability filter ahead of edge detection.
module blink_meter #(
    parameter int WIDTH      = 16,
    parameter int MIN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             blink_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);
    typedef enum logic {IDLE, MEASURE} state_t;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] MIN_CNT = WIDTH'(MIN_PERIOD);

    state_t           state, state_nx;
    logic             s1, s2, s3, sf, rise, fall;
    logic             start, accept, sat, latch;
    logic [WIDTH-1:0] cnt, hcnt, hi_lat;

    if (MIN_PERIOD < 2) begin : g_min_check
        $error("blink_meter: MIN_PERIOD must be at least 2");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= blink_in;
            s2 <= s1;
        end
    end

`ifdef BLINK_METER_GLITCH_EN
    logic [1:0] hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hist <= '0;
        else
            hist <= {hist[0], s2};
    end
    // the filtered level moves only once s2 has been steady for three samples
    assign sf = (s2 == hist[0] && s2 == hist[1]) ? s2 : s3;
`else
    assign sf = s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s3 <= 1'b0;
        else
            s3 <= sf;
    end

    assign rise = sf & ~s3;
    assign fall = ~sf & s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = !ena ? IDLE :
                   (state == IDLE) ? (rise ? MEASURE : IDLE) :
                   (sat ? IDLE : MEASURE);
    end

    // a rise on the saturating cycle wins over the timeout
    always_comb begin
        start  = ena && state == IDLE && rise;
        accept = ena && state == MEASURE && rise && cnt >= MIN_CNT;
        sat    = ena && state == MEASURE && !rise && cnt == CNT_MAX;
        latch  = ena && state == MEASURE && fall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            hcnt      <= '0;
            hi_lat    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid  <= accept;
            locked <= accept | (locked & ena & ~sat);
            if (!ena) begin
                cnt  <= '0;
                hcnt <= '0;
            end else if (start || accept) begin
                cnt  <= WIDTH'(1);
                hcnt <= WIDTH'(1);
            end else if (state == MEASURE) begin
                cnt  <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                hcnt <= hcnt + WIDTH'(s3);
            end
            if (latch)
                hi_lat <= hcnt;
            if (accept) begin
                period    <= cnt;
                high_time <= hi_lat;
                timeout   <= 1'b0;
            end
            if (sat)
                timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_blink_meter.sv
// tb_blink_meter: randomized blink waveforms checked against an edge/interval reference model.
module tb_blink_meter;
    localparam int W    = 8;
    localparam int MINP = 4;
    localparam int NMAX = 8192;
    localparam int SATV = (1 << W) - 1;

    logic         clk, rst, ena, blink_in, valid, locked, timeout;
    logic [W-1:0] period, high_time;

    int checks, failures, t, a, hi;
    int e_period, e_high;
    bit e_valid, e_locked, e_timeout, meas;
    bit bh[NMAX];
    bit lv[NMAX];

    blink_meter #(.WIDTH(W), .MIN_PERIOD(MINP)) dut (
        .clk(clk), .rst(rst), .ena(ena), .blink_in(blink_in),
        .period(period), .high_time(high_time),
        .valid(valid), .locked(locked), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit bget(input int i);
        return (i < 0) ? 1'b0 : bh[i];
    endfunction

    // level seen by edge detection in cycle t, then edge/interval bookkeeping
    task automatic model_step(input bit ev);
        bit r, f;
`ifdef BLINK_METER_GLITCH_EN
        lv[t] = (bget(t-2) == bget(t-3) && bget(t-3) == bget(t-4)) ? bget(t-2) : lv[t-1];
`else
        lv[t] = bget(t-2);
`endif
        r = lv[t] && !lv[t-1];
        f = !lv[t] && lv[t-1];
        e_valid = 1'b0;
        if (!ev) begin
            meas = 1'b0;
            e_locked = 1'b0;
        end else if (!meas) begin
            if (r) begin
                meas = 1'b1;
                a = t;
            end
        end else begin
            if (f) begin
                hi = 0;
                for (int i = a; i < t; i++) hi += int'(lv[i]);
            end
            if (r && t - a >= MINP) begin
                e_period = t - a;
                e_high = hi;
                e_valid = 1'b1;
                e_locked = 1'b1;
                e_timeout = 1'b0;
                a = t;
            end else if (!r && t - a >= SATV) begin
                e_timeout = 1'b1;
                e_locked = 1'b0;
                meas = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit bv, input bit ev);
        @(posedge clk);
        #1;
        if (t >= NMAX - 2) begin
            $display("FAIL history: cycle budget %0d exceeded", t);
            $fatal(1);
        end
        t++;
        blink_in = bv;
        ena = ev;
        bh[t] = bv;
        #3;
        chk("valid", int'(valid), int'(e_valid));
        chk("locked", int'(locked), int'(e_locked));
        chk("timeout", int'(timeout), int'(e_timeout));
        chk("period", int'(period), e_period);
        chk("high_time", int'(high_time), e_high);
        model_step(ev);
    endtask

    task automatic wave(input int h, input int l, input int n, input bit ev);
        repeat (n) begin
            repeat (h) cyc(1'b1, ev);
            repeat (l) cyc(1'b0, ev);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high"}, int'(high_time), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        int bc;
        bit bl;
        checks = 0; failures = 0; t = 0; a = 0; hi = 0; meas = 1'b0;
        e_period = 0; e_high = 0; e_valid = 1'b0; e_locked = 1'b0; e_timeout = 1'b0;
        rst = 1'b1; ena = 1'b0; blink_in = 1'b0;
        #12;
        chk_reset("rst_init");
        @(negedge clk);
        rst = 1'b0;
        wave(5, 3, 6, 1'b1);
        chk("clean_period", int'(period), 8);
        chk("clean_high", int'(high_time), 5);
        chk("clean_locked", int'(locked), 1);
        repeat (5) begin
            wave(1, 1, 1, 1'b1);
            wave(1, 7, 1, 1'b1);
        end
`ifdef BLINK_METER_GLITCH_EN
        chk("glitch_period", int'(period), 8);
        chk("glitch_high", int'(high_time), 5);
`else
        chk("glitch_period", int'(period), 10);
`endif
        repeat (40) wave($urandom_range(1, 6), $urandom_range(1, 6), 1, 1'b1);
        wave(5, 3, 4, 1'b1);
        wave(5, 3, 2, 1'b0);
        repeat (4) cyc(1'b1, 1'b0);
        chk("gap_locked", int'(locked), 0);
        wave(5, 3, 4, 1'b1);
        wave(5, 3, 3, 1'b1);
        repeat (300) cyc(1'b0, 1'b1);
        chk("to_timeout", int'(timeout), 1);
        chk("to_locked", int'(locked), 0);
        chk("to_period", int'(period), 8);
        wave(5, 3, 3, 1'b1);
        chk("to_cleared", int'(timeout), 0);
        chk("to_relocked", int'(locked), 1);
        bc = 0;
        bl = 1'b0;
        repeat (144) begin
            cyc(bl, 1'b1);
            bc++;
            if (bc == 6) begin
                bc = 0;
                bl = ~bl;
            end
        end
        chk("loop_period", int'(period), 12);
        chk("loop_high", int'(high_time), 6);
        chk("loop_locked", int'(locked), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_async");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
